dict_loader: RTL and testbench
==============================

DICT_LOADER -- requirements
Module: dict_loader

Interface
REQ-001 SHALL have parameter FIELD1_VAL_WIDTH, default 7, width of a field-1 dictionary value.
REQ-002 SHALL have parameter FIELD2_VAL_WIDTH, default 12, width of a field-2 dictionary value.
REQ-003 SHALL have parameter FIELD3_VAL_WIDTH, default 13, width of a field-3 dictionary value.
REQ-004 SHALL have parameters FIELD1/2/3_KEY_WIDTH, defaults 3/6/7; the capacity of dictionary N is 2^FIELDN_KEY_WIDTH entries.
REQ-005 SHALL have parameter DICT_BASE_ADDR, default 32'h0001_0000, the byte address of the dictionary image header.
REQ-006 SHALL have port clk, input, 1, the single clock.
REQ-007 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port start, input, 1, a one-cycle load request.
REQ-009 SHALL have ports mem_req_valid (output, 1), mem_req_ready (input, 1), mem_req_addr (output, 32) and mem_req_rdata (input, 32), a word-read port to backing memory.
REQ-010 SHALL have ports dictN_write_enable (output, 1) and dictN_write_val (output, FIELDN_VAL_WIDTH) for N=1..3, which feed the controller's dictionary write inputs.
REQ-011 SHALL have ports busy, done and error, each an output of width 1; busy holds the processor off.

Function
REQ-012 The image SHALL be laid out as: header word (bits [7:0]=n1, [15:8]=n2, [23:16]=n3, [31:24]=magic 8'hD1), then n1 field-1 words, n2 field-2 words and n3 field-3 words at consecutive word addresses; each value is the low FIELDN_VAL_WIDTH bits of its word.
REQ-013 The FSM SHALL have the states IDLE, HDR, F1, F2, F3, DONE and ERR.
REQ-014 In IDLE, DONE or ERR, start=1 SHALL enter HDR and clear done and error; start is ignored while in HDR, F1, F2 or F3.
REQ-015 Memory handshake: mem_req_valid is held high with a stable mem_req_addr until mem_req_ready=1; mem_req_rdata is captured in that cycle; valid is then low for exactly one cycle before the next request.
REQ-016 Word k SHALL be read at address DICT_BASE_ADDR + 4*k, where k=0 is the header.
REQ-017 The header SHALL cause a transition to ERR, with no dictionary writes, if magic != 8'hD1 or nN > 2^FIELDN_KEY_WIDTH for any N.
REQ-018 A field with nN=0 SHALL be skipped, with no memory read and no write; if all counts are 0, the FSM goes HDR -> DONE.
REQ-019 For each entry word, dictN_write_enable SHALL pulse for exactly one cycle, the cycle after the mem_req_ready capture, with dictN_write_val equal to the captured value. At most one write_enable is high in any cycle, and entries are written in image order.
REQ-020 After the last entry of the last non-empty field, the FSM SHALL enter DONE: done=1, busy=0.
REQ-021 busy SHALL be 1 in states HDR, F1, F2 and F3 only; error SHALL be 1 in ERR only.
REQ-022 The per-field entry counter SHALL be 8 bits wide; the word address is computed in 32 bits and wraps modulo 2^32 with no error.

Reset
REQ-023 resetn=0 SHALL asynchronously force state to IDLE and all outputs to 0, including mem_req_addr and the dictN_write_val buses.
REQ-024 A reset asserted mid-load SHALL abandon the load with no further writes; entries already written are not rolled back.

Configuration
REQ-025 Macro DICT_LOADER_CHECKSUM_EN, when defined, SHALL add a state CSUM. This state reads one extra word after the last entry: the XOR of all entry words. On mismatch the FSM goes to ERR, otherwise to DONE. The write pulses already issued still stand.
REQ-026 When DICT_LOADER_CHECKSUM_EN is undefined, there SHALL be no CSUM state and no checksum word is read.

Verification
REQ-027 Header 32'hD1_01_02_03 with mem_req_ready returned 2 cycles after each valid -> 3 dict1, 2 dict2 and 1 dict3 write pulses in order, with addresses base+4..base+24; then done=1 and busy=0.
REQ-028 Header magic 8'hA5 -> error=1 after one read, zero write pulses, busy=0.
REQ-029 Header n1=9 (greater than 8 for KEY_WIDTH 3) -> ERR, zero writes.
REQ-030 Header 32'hD1_00_00_00 -> DONE after the single header read, no writes.
REQ-031 resetn dropped after the 2nd write pulse -> all outputs 0 immediately, no further pulses; a later start performs a full reload.
REQ-032 With DICT_LOADER_CHECKSUM_EN defined and a corrupted checksum word -> all writes occur, then error=1 and done=0.

Source files
------------

// File: rtl/dict_loader.sv
// Streams a dictionary image (header + field words) from word memory into three dictionary write ports.
// Optional DICT_LOADER_CHECKSUM_EN appends a trailing XOR word that is verified before DONE.
module dict_loader #(
  parameter int          FIELD1_VAL_WIDTH = 7,
  parameter int          FIELD2_VAL_WIDTH = 12,
  parameter int          FIELD3_VAL_WIDTH = 13,
  parameter int          FIELD1_KEY_WIDTH = 3,
  parameter int          FIELD2_KEY_WIDTH = 6,
  parameter int          FIELD3_KEY_WIDTH = 7,
  parameter logic [31:0] DICT_BASE_ADDR   = 32'h0001_0000
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        start,
  output logic                        mem_req_valid,
  input  logic                        mem_req_ready,
  output logic [31:0]                 mem_req_addr,
  input  logic [31:0]                 mem_req_rdata,
  output logic                        dict1_write_enable,
  output logic [FIELD1_VAL_WIDTH-1:0] dict1_write_val,
  output logic                        dict2_write_enable,
  output logic [FIELD2_VAL_WIDTH-1:0] dict2_write_val,
  output logic                        dict3_write_enable,
  output logic [FIELD3_VAL_WIDTH-1:0] dict3_write_val,
  output logic                        busy,
  output logic                        done,
  output logic                        error
);

  typedef enum logic [2:0] {
    IDLE, HDR, F1, F2, F3, DONE, ERR
`ifdef DICT_LOADER_CHECKSUM_EN
    , CSUM
`endif
  } state_t;

  state_t      state;
  state_t      adv_state;
  logic [7:0]  n1_q, n2_q, n3_q;
  logic [7:0]  cnt;
  logic [7:0]  cur_n;
  logic [1:0]  cur_idx;
  logic        hdr_bad;
  logic        cap;
`ifdef DICT_LOADER_CHECKSUM_EN
  logic [31:0] csum;
`endif

  // First non-empty field after position 'after' (0 = header), else the terminal state.
  function automatic state_t next_field(input logic [1:0] after,
                                        input logic [7:0] c1, input logic [7:0] c2,
                                        input logic [7:0] c3);
    if (after == 2'd0 && c1 != 8'd0) return F1;
    if (after <= 2'd1 && c2 != 8'd0) return F2;
    if (after <= 2'd2 && c3 != 8'd0) return F3;
`ifdef DICT_LOADER_CHECKSUM_EN
    if (after != 2'd0) return CSUM;
`endif
    return DONE;
  endfunction

  assign cap = mem_req_valid && mem_req_ready;

  assign hdr_bad = (mem_req_rdata[31:24] != 8'hD1) ||
                   (32'(mem_req_rdata[7:0])   > (32'd1 << FIELD1_KEY_WIDTH)) ||
                   (32'(mem_req_rdata[15:8])  > (32'd1 << FIELD2_KEY_WIDTH)) ||
                   (32'(mem_req_rdata[23:16]) > (32'd1 << FIELD3_KEY_WIDTH));

  always_comb begin
    cur_idx = 2'd0;
    cur_n   = n1_q;
    case (state)
      F1:      begin cur_idx = 2'd1; cur_n = n1_q; end
      F2:      begin cur_idx = 2'd2; cur_n = n2_q; end
      F3:      begin cur_idx = 2'd3; cur_n = n3_q; end
      default: begin cur_idx = 2'd0; cur_n = n1_q; end
    endcase
    if (state == HDR)
      adv_state = next_field(2'd0, mem_req_rdata[7:0], mem_req_rdata[15:8], mem_req_rdata[23:16]);
    else
      adv_state = next_field(cur_idx, n1_q, n2_q, n3_q);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state              <= IDLE;
      mem_req_valid      <= 1'b0;
      mem_req_addr       <= 32'd0;
      dict1_write_enable <= 1'b0;
      dict1_write_val    <= '0;
      dict2_write_enable <= 1'b0;
      dict2_write_val    <= '0;
      dict3_write_enable <= 1'b0;
      dict3_write_val    <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      error              <= 1'b0;
      n1_q               <= 8'd0;
      n2_q               <= 8'd0;
      n3_q               <= 8'd0;
      cnt                <= 8'd0;
`ifdef DICT_LOADER_CHECKSUM_EN
      csum               <= 32'd0;
`endif
    end else begin
      dict1_write_enable <= 1'b0;
      dict2_write_enable <= 1'b0;
      dict3_write_enable <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state         <= HDR;
            mem_req_valid <= 1'b1;
            mem_req_addr  <= DICT_BASE_ADDR;
            busy          <= 1'b1;
            done          <= 1'b0;
            error         <= 1'b0;
            cnt           <= 8'd0;
`ifdef DICT_LOADER_CHECKSUM_EN
            csum          <= 32'd0;
`endif
          end
        end
        HDR: begin
          if (cap) begin
            mem_req_valid <= 1'b0;
            mem_req_addr  <= mem_req_addr + 32'd4;
            n1_q          <= mem_req_rdata[7:0];
            n2_q          <= mem_req_rdata[15:8];
            n3_q          <= mem_req_rdata[23:16];
            if (hdr_bad) begin
              state <= ERR;
              busy  <= 1'b0;
              error <= 1'b1;
            end else begin
              state <= adv_state;
              busy  <= (adv_state != DONE);
              done  <= (adv_state == DONE);
            end
          end
        end
        F1, F2, F3: begin
          // Valid is only low here for the single gap cycle after a capture.
          if (!mem_req_valid) begin
            mem_req_valid <= 1'b1;
          end else if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            mem_req_addr  <= mem_req_addr + 32'd4;
`ifdef DICT_LOADER_CHECKSUM_EN
            csum          <= csum ^ mem_req_rdata;
`endif
            case (state)
              F1: begin
                dict1_write_enable <= 1'b1;
                dict1_write_val    <= mem_req_rdata[FIELD1_VAL_WIDTH-1:0];
              end
              F2: begin
                dict2_write_enable <= 1'b1;
                dict2_write_val    <= mem_req_rdata[FIELD2_VAL_WIDTH-1:0];
              end
              default: begin
                dict3_write_enable <= 1'b1;
                dict3_write_val    <= mem_req_rdata[FIELD3_VAL_WIDTH-1:0];
              end
            endcase
            if (cnt == cur_n - 8'd1) begin
              cnt   <= 8'd0;
              state <= adv_state;
              busy  <= (adv_state != DONE);
              done  <= (adv_state == DONE);
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
`ifdef DICT_LOADER_CHECKSUM_EN
        CSUM: begin
          if (!mem_req_valid) begin
            mem_req_valid <= 1'b1;
          end else if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            mem_req_addr  <= mem_req_addr + 32'd4;
            busy          <= 1'b0;
            if (mem_req_rdata != csum) begin
              state <= ERR;
              error <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dict_loader.sv
// Scoreboard bench for dict_loader: stimulus pushes expected reads/writes, a negedge monitor pops and compares.
module tb_dict_loader;

  localparam logic [31:0] BASE = 32'h0001_0000;
`ifdef DICT_LOADER_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_rdata;
  logic        we1, we2, we3;
  logic [6:0]  val1;
  logic [11:0] val2;
  logic [12:0] val3;
  logic        busy, done, error;

  dict_loader dut (
    .clk(clk), .resetn(resetn), .start(start),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_rdata(mem_req_rdata),
    .dict1_write_enable(we1), .dict1_write_val(val1),
    .dict2_write_enable(we2), .dict2_write_val(val2),
    .dict3_write_enable(we3), .dict3_write_val(val3),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  f;
    logic [12:0] v;
  } wr_t;

  int          tests_run = 0;
  int          tests_failed = 0;
  int          n_writes = 0;
  int          n_reads = 0;
  logic [31:0] mem [0:31];
  wr_t         exp_wr[$];
  logic [31:0] exp_addr[$];
  logic [31:0] bad_hdr [0:3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    tests_run++;
    tests_failed++;
    $display("FAIL %s: got %h with nothing expected", name, act);
  endtask

  // Memory responder: ready rises two cycles after valid, data from the image array.
  initial begin : responder
    int wait_cnt;
    logic [31:0] wi;
    wait_cnt = 0;
    mem_req_ready = 1'b0;
    mem_req_rdata = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req_valid && !mem_req_ready) begin
        wait_cnt++;
        if (wait_cnt >= 2) begin
          wi = (mem_req_addr - BASE) >> 2;
          mem_req_ready = 1'b1;
          mem_req_rdata = mem[wi[4:0]];
        end
      end else begin
        mem_req_ready = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  initial begin : monitor
    logic last_cap;
    int   hot;
    wr_t  e;
    logic [1:0]  af;
    logic [12:0] av;
    last_cap = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        last_cap = 1'b0;
      end else begin
        if (last_cap) check("req_gap", 32'(mem_req_valid), 32'd0);
        last_cap = mem_req_valid && mem_req_ready;
        if (last_cap) begin
          n_reads++;
          if (exp_addr.size() == 0) fail_now("unexpected_read", mem_req_addr);
          else check("read_addr", mem_req_addr, exp_addr.pop_front());
        end
        hot = int'(we1) + int'(we2) + int'(we3);
        if (hot != 0) begin
          n_writes++;
          check("we_onehot", 32'(hot), 32'd1);
          af = we1 ? 2'd1 : (we2 ? 2'd2 : 2'd3);
          av = we1 ? {6'd0, val1} : (we2 ? {1'b0, val2} : val3);
          if (exp_wr.size() == 0) begin
            fail_now("unexpected_write", {17'd0, af, av});
          end else begin
            e = exp_wr.pop_front();
            check("wr_field", 32'(af), 32'(e.f));
            check("wr_val", 32'(av), 32'(e.v));
          end
        end
      end
    end
  end

  task automatic push_wr(input logic [1:0] f, input logic [12:0] v);
    exp_wr.push_back('{f: f, v: v});
  endtask

  task automatic push_addrs(input int nwords);
    for (int k = 0; k < nwords; k++) exp_addr.push_back(BASE + 32'(4 * k));
  endtask

  function automatic logic [31:0] xor_words(input int first, input int last);
    logic [31:0] x;
    x = 32'd0;
    for (int k = first; k <= last; k++) x = x ^ mem[k];
    return x;
  endfunction

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input string name);
    int i;
    for (i = 0; i < 500; i++) begin
      @(negedge clk);
      if (done || error) break;
    end
    if (i == 500) fail_now({name, "_timeout"}, {30'd0, done, error});
    @(posedge clk);
    #2;
  endtask

  task automatic wait_writes(input int n);
    int i;
    for (i = 0; i < 500; i++) begin
      @(negedge clk);
      if (n_writes >= n) break;
    end
    if (i == 500) fail_now("write_wait_timeout", 32'(n_writes));
  endtask

  task automatic end_check(input string name, input logic exp_done, input logic exp_err,
                           input int exp_writes, input int exp_reads);
    check({name, "_done"}, 32'(done), 32'(exp_done));
    check({name, "_error"}, 32'(error), 32'(exp_err));
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_writes"}, 32'(n_writes), 32'(exp_writes));
    check({name, "_reads"}, 32'(n_reads), 32'(exp_reads));
    check({name, "_wr_left"}, 32'(exp_wr.size()), 32'd0);
    check({name, "_rd_left"}, 32'(exp_addr.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_valid"}, 32'(mem_req_valid), 32'd0);
    check({name, "_addr"}, mem_req_addr, 32'd0);
    check({name, "_we"}, {29'd0, we1, we2, we3}, 32'd0);
    check({name, "_vals"}, {val1, val2, val3}, 32'd0);
    check({name, "_status"}, {29'd0, busy, done, error}, 32'd0);
  endtask

  // Header 3/2/1 image with truncation corner values.
  task automatic load_image_321();
    mem[0] = 32'hD101_0203;
    mem[1] = 32'h0000_0011;
    mem[2] = 32'hABCD_EF7F;
    mem[3] = 32'h0000_0080;
    mem[4] = 32'h1234_5ABC;
    mem[5] = 32'h0000_0FFF;
    mem[6] = 32'hFFFF_E123;
    mem[7] = xor_words(1, 6);
  endtask

  task automatic expect_321();
    push_wr(2'd1, 13'h0011);
    push_wr(2'd1, 13'h007F);
    push_wr(2'd1, 13'h0000);
    push_wr(2'd2, 13'h0ABC);
    push_wr(2'd2, 13'h0FFF);
    push_wr(2'd3, 13'h0123);
    push_addrs(7 + CS);
  endtask

  task automatic clear_counts();
    n_writes = 0;
    n_reads = 0;
  endtask

  initial begin
    for (int k = 0; k < 32; k++) mem[k] = 32'd0;
    bad_hdr[0] = 32'hA501_0203;
    bad_hdr[1] = 32'hD100_0009;
    bad_hdr[2] = 32'hD100_4100;
    bad_hdr[3] = 32'hD181_0000;
    start  = 1'b0;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    resetn = 1'b1;
    @(negedge clk);

    // Full load, with a stray start while busy that must be ignored.
    load_image_321();
    expect_321();
    clear_counts();
    do_start();
    wait_writes(1);
    do_start();
    wait_end("load321");
    end_check("load321", 1'b1, 1'b0, 6, 7 + CS);

    // Rejected headers: bad magic, then each field count one past capacity.
    for (int t = 0; t < 4; t++) begin
      mem[0] = bad_hdr[t];
      push_addrs(1);
      clear_counts();
      do_start();
      wait_end("bad_hdr");
      end_check("bad_hdr", 1'b0, 1'b1, 0, 1);
    end

    // All-empty header.
    mem[0] = 32'hD100_0000;
    push_addrs(1);
    clear_counts();
    do_start();
    wait_end("empty");
    end_check("empty", 1'b1, 1'b0, 0, 1);

    // Field 1 at full capacity (8 entries).
    mem[0] = 32'hD100_0008;
    for (int k = 1; k <= 8; k++) begin
      mem[k] = 32'hFFFF_FF00 + 32'(k);
      push_wr(2'd1, 13'(k));
    end
    mem[9] = xor_words(1, 8);
    push_addrs(9 + CS);
    clear_counts();
    do_start();
    wait_end("cap8");
    end_check("cap8", 1'b1, 1'b0, 8, 9 + CS);

    // Fields 1 and 2 empty, field 3 only.
    mem[0] = 32'hD102_0000;
    mem[1] = 32'h0000_1FFF;
    mem[2] = 32'h0001_2000;
    mem[3] = xor_words(1, 2);
    push_wr(2'd3, 13'h1FFF);
    push_wr(2'd3, 13'h0000);
    push_addrs(3 + CS);
    clear_counts();
    do_start();
    wait_end("skip12");
    end_check("skip12", 1'b1, 1'b0, 2, 3 + CS);

    // Reset after the second write pulse, then a full reload.
    load_image_321();
    expect_321();
    clear_counts();
    do_start();
    wait_writes(2);
    #1;
    resetn = 1'b0;
    #1;
    check_all_zero("midreset");
    exp_wr.delete();
    exp_addr.delete();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    check("midreset_no_more_writes", 32'(n_writes), 32'd2);
    check("midreset_idle_busy", 32'(busy), 32'd0);
    expect_321();
    clear_counts();
    do_start();
    wait_end("reload");
    end_check("reload", 1'b1, 1'b0, 6, 7 + CS);

`ifdef DICT_LOADER_CHECKSUM_EN
    // Corrupted checksum word: every write still issued, then error.
    load_image_321();
    mem[7] = xor_words(1, 6) ^ 32'h0000_0001;
    expect_321();
    clear_counts();
    do_start();
    wait_end("badcsum");
    end_check("badcsum", 1'b0, 1'b1, 6, 8);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
